uart_tx: RTL and testbench

Serial UART transmitter and the transmit-side counterpart of `uart_rx` in the APB UART. It accepts bytes over a valid/ready handshake into a one-entry holding register. It serialises each byte as start bit, 8 data bits LSB first, optional parity bit and one stop bit, with every bit held for exactly `BitTicks` clock cycles. Bytes presented early enough go out back-to-back with no idle gap between frames.

---
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-entry holding register.
// Frame format: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
// Every serial bit lasts exactly BitTicks clock cycles. A byte that is already held
// when the stop bit ends goes out in the next cycle, with no idle gap.
`timescale 1ns/1ps
module uart_tx #(
   parameter int BitTicks = 16
) (
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic [7:0] data_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   input  logic       parity_en_i,
   input  logic       parity_type_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       frame_done_o
);

   localparam int TickW = $clog2(BitTicks);
   localparam logic [TickW-1:0] TickLast = TickW'(BitTicks - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [TickW-1:0] tick_q;
   logic [2:0]       bit_idx_q;
   logic [2:0]       bit_idx_d;
   logic [7:0]       hold_q;
   logic             hold_full_q;
   logic [7:0]       shift_q;
   logic             par_en_q;
   logic             par_bit_q;
   logic             tx_q;
   logic             tx_d;
   logic             frame_done_q;
   logic             frame_done_d;
   logic             bit_end;
   logic             accept;
   logic             load;

   assign bit_end = (tick_q == TickLast);
   // The ready flag depends only on hold_full_q, so nothing combinational runs from valid to ready.
   assign accept  = data_valid_i && !hold_full_q;
   // A held byte is loaded either straight from idle or at the end of the stop bit.
   assign load    = hold_full_q &&
                    ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));

   assign data_ready_o = !hold_full_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign tx_o         = tx_q;
   assign frame_done_o = frame_done_q;

   // State register plus all control flags; reset forces the line high immediately.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q      <= ST_IDLE;
         tick_q       <= '0;
         bit_idx_q    <= '0;
         hold_full_q  <= 1'b0;
         par_en_q     <= 1'b0;
         tx_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_idx_q    <= bit_idx_d;
         tx_q         <= tx_d;
         frame_done_q <= frame_done_d;
         if (state_q == ST_IDLE || bit_end) begin
            tick_q <= '0;
         end else begin
            tick_q <= tick_q + TickW'(1);
         end
         if (load) begin
            hold_full_q <= 1'b0;
         end else if (accept) begin
            hold_full_q <= 1'b1;
         end
         if (load) begin
            par_en_q <= parity_en_i;
         end
      end
   end

   // Data registers (holding byte, shift byte, latched parity bit) carry no reset.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         hold_q <= data_i;
      end
      if (load) begin
         shift_q   <= hold_q;
         par_bit_q <= parity_type_i ? ~^hold_q : ^hold_q;
      end
   end

   // Next-state logic: the frame advances one bit at each bit_end.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (hold_full_q) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx_q != 3'd7) begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end else begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               state_d = hold_full_q ? ST_START : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: the line level of the state being entered, registered on the same edge.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_q[bit_idx_d];
         ST_PARITY: tx_d = par_bit_q;
         default:   tx_d = 1'b1;
      endcase
      frame_done_d = (state_q == ST_STOP) && bit_end;
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized bench for uart_tx.
// The expected line waveform is built from the frame format: start, data LSB first,
// parity derived from a population count, and stop, with each bit held BT cycles.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int BT = 16;

   logic       clk = 1'b0;
   logic       arst = 1'b1;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       pe = 1'b0;
   logic       pt = 1'b0;
   logic       tx;
   logic       ready;
   logic       busy;
   logic       fd;

   int n_cmp = 0;
   int n_err = 0;
   int hs_cnt = 0;

   uart_tx #(.BitTicks(BT)) dut (
      .clk_i         (clk),
      .arst_i        (arst),
      .data_i        (data),
      .data_valid_i  (valid),
      .data_ready_o  (ready),
      .parity_en_i   (pe),
      .parity_type_i (pt),
      .tx_o          (tx),
      .busy_o        (busy),
      .frame_done_o  (fd)
   );

   always #5 clk = ~clk;

   // Handshake counter: valid and ready are both stable at the falling edge.
   always @(negedge clk) begin
      if (valid && ready && !arst) hs_cnt <= hs_cnt + 1;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transfers one byte: raises valid, waits for ready, returns one cycle after the handshake.
   task automatic send(input logic [7:0] b, input string tag);
      int w = 0;
      @(posedge clk); #1;
      data  = b;
      valid = 1'b1;
      @(negedge clk);
      while (!ready && w < 4000) begin
         @(negedge clk);
         w++;
      end
      check($sformatf("%s accept_wait", tag), 32'(w < 4000), 32'd1);
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   // Call just after the edge that starts the start bit; returns at the falling edge
   // of the last stop-bit cycle. fd0 is frame_done seen in the first start-bit cycle.
   task automatic expect_frame(input logic [7:0] b, input logic p_en, input logic p_odd,
                               input string tag, output logic fd0);
      logic bits[$];
      int   fd_hits = 0;
      int   busy_lo = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      if (p_en) bits.push_back((($countones(b) % 2) == 1) ^ p_odd);
      bits.push_back(1'b1);
      fd0 = 1'b0;
      foreach (bits[j]) begin
         logic [BT-1:0] obs;
         logic [BT-1:0] exp_v;
         exp_v = bits[j] ? '1 : '0;
         for (int t = 0; t < BT; t++) begin
            @(negedge clk);
            obs[t] = tx;
            if (j == 0 && t == 0) fd0 = fd;
            else if (fd) fd_hits++;
            if (!busy) busy_lo++;
         end
         check($sformatf("%s bit%0d", tag, j), 32'(obs), 32'(exp_v));
      end
      check($sformatf("%s done_in_frame", tag), fd_hits, 0);
      check($sformatf("%s busy_low", tag), busy_lo, 0);
   endtask

   initial begin
      logic       f0;
      int         hs0;
      int         lows;
      int         fds;
      logic [7:0] seq [3];
      logic [7:0] rb;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst tx", 32'(tx), 32'd1);
      check("rst ready", 32'(ready), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(fd), 32'd0);
      @(posedge clk); #1;
      arst = 1'b0;
      @(negedge clk);
      check("post_rst tx", 32'(tx), 32'd1);

      // Single byte 0x55, no parity
      pe = 1'b0; pt = 1'b0;
      send(8'h55, "t1");
      @(negedge clk);
      check("t1 pre_start tx", 32'(tx), 32'd1);
      check("t1 pre_start busy", 32'(busy), 32'd0);
      check("t1 held ready", 32'(ready), 32'd0);
      @(posedge clk); #1;
      expect_frame(8'h55, 1'b0, 1'b0, "t1", f0);
      check("t1 done_at_start", 32'(f0), 32'd0);
      @(negedge clk);
      check("t1 done", 32'(fd), 32'd1);
      check("t1 busy_drop", 32'(busy), 32'd0);
      check("t1 ready", 32'(ready), 32'd1);
      @(negedge clk);
      check("t1 done_once", 32'(fd), 32'd0);

      // Parity 0xA3: even then odd, with parity_type toggled mid-frame
      pe = 1'b1; pt = 1'b0;
      send(8'hA3, "t2e");
      @(posedge clk); #1;
      fork
         expect_frame(8'hA3, 1'b1, 1'b0, "t2e", f0);
         begin repeat (40) @(posedge clk); #1; pt = 1'b1; end
      join
      @(negedge clk);
      check("t2e done", 32'(fd), 32'd1);
      send(8'hA3, "t2o");
      @(posedge clk); #1;
      fork
         expect_frame(8'hA3, 1'b1, 1'b1, "t2o", f0);
         begin repeat (40) @(posedge clk); #1; pt = 1'b0; end
      join
      @(negedge clk);
      check("t2o done", 32'(fd), 32'd1);

      // Back-to-back 0x01, 0x80, 0xFF with valid held high
      pe = 1'b0;
      seq[0] = 8'h01; seq[1] = 8'h80; seq[2] = 8'hFF;
      @(posedge clk); #1;
      hs0 = hs_cnt;
      fork
         begin
            valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
               int w = 0;
               data = seq[k];
               @(negedge clk);
               while (!ready && w < 4000) begin
                  @(negedge clk);
                  w++;
               end
               check($sformatf("t3 accept_wait%0d", k), 32'(w < 4000), 32'd1);
               @(posedge clk); #1;
               @(negedge clk);
               check($sformatf("t3 held_ready%0d", k), 32'(ready), 32'd0);
               if (k == 1) begin
                  repeat (100) @(negedge clk);
                  check("t3 held_ready_mid", 32'(ready), 32'd0);
               end
            end
            valid = 1'b0;
         end
         begin
            int w = 0;
            while (tx !== 1'b0 && w < 100) begin
               @(posedge clk); #1;
               w++;
            end
            check("t3 start_seen", 32'(w < 100), 32'd1);
            for (int k = 0; k < 3; k++) begin
               expect_frame(seq[k], 1'b0, 1'b0, $sformatf("t3f%0d", k), f0);
               check($sformatf("t3f%0d done_at_start", k), 32'(f0), 32'(k > 0));
            end
            @(negedge clk);
            check("t3 done", 32'(fd), 32'd1);
            check("t3 busy_drop", 32'(busy), 32'd0);
         end
      join
      @(posedge clk); #1;
      check("t3 handshakes", hs_cnt - hs0, 3);

      // Late write in the final stop-bit cycle
      send(8'hC6, "t4a");
      @(posedge clk); #1;
      repeat (159) begin @(posedge clk); #1; end
      data  = 8'h3A;
      valid = 1'b1;
      @(negedge clk);
      check("t4 last_stop tx", 32'(tx), 32'd1);
      check("t4 last_stop busy", 32'(busy), 32'd1);
      check("t4 last_stop ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
      check("t4 gap tx", 32'(tx), 32'd1);
      check("t4 gap busy", 32'(busy), 32'd0);
      check("t4 gap done", 32'(fd), 32'd1);
      @(posedge clk); #1;
      expect_frame(8'h3A, 1'b0, 1'b0, "t4b", f0);
      check("t4b done_at_start", 32'(f0), 32'd0);
      @(negedge clk);
      check("t4b done", 32'(fd), 32'd1);

      // Reset during DATA bit 4 with a byte held
      send(8'h0F, "t5a");
      send(8'hB4, "t5b");
      repeat (87) begin @(posedge clk); #1; end
      @(negedge clk);
      check("t5 bit4 tx", 32'(tx), 32'd0);
      check("t5 held ready", 32'(ready), 32'd0);
      #2;
      arst = 1'b1;
      #1;
      check("t5 rst tx", 32'(tx), 32'd1);
      check("t5 rst ready", 32'(ready), 32'd1);
      check("t5 rst busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      arst = 1'b0;
      lows = 0;
      fds  = 0;
      repeat (250) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
         if (fd !== 1'b0) fds++;
      end
      check("t5 quiet_line", lows, 0);
      check("t5 no_done", fds, 0);
      send(8'h9C, "t5c");
      @(posedge clk); #1;
      expect_frame(8'h9C, 1'b0, 1'b0, "t5c", f0);
      @(negedge clk);
      check("t5c done", 32'(fd), 32'd1);

      // Randomized bytes and parity settings
      for (int i = 0; i < 20; i++) begin
         rb = 8'($urandom);
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 5)) @(posedge clk);
         send(rb, $sformatf("r%0d", i));
         @(posedge clk); #1;
         expect_frame(rb, pe, pt, $sformatf("r%0d", i), f0);
         @(negedge clk);
         check($sformatf("r%0d done", i), 32'(fd), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
